// File: rtl/uart_alu_sequencer_if.sv
//==============================================================================
// Module      : uart_alu_sequencer_if
// Description : Bus between the UART/ALU command sequencer and its environment.
//               o_op_err exists only when UART_ALU_SEQ_OPCHECK_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_alu_sequencer_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;
`ifdef UART_ALU_SEQ_OPCHECK_EN
    logic               o_op_err;
`endif

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
`ifdef UART_ALU_SEQ_OPCHECK_EN
        output o_op_err,
`endif
        output o_busy, o_timeout, o_overrun
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
`ifdef UART_ALU_SEQ_OPCHECK_EN
        input  o_op_err,
`endif
        input  o_busy, o_timeout, o_overrun
    );
endinterface

`default_nettype wire

// File: rtl/uart_alu_sequencer.sv
//==============================================================================
// Module      : uart_alu_sequencer
// Description : Gathers A, B, opcode from UART RX, drives the ALU and sends the
//               result via UART TX. Optional opcode check: UART_ALU_SEQ_OPCHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_alu_sequencer #(
    parameter int                 NB_DATA        = 8,
    parameter int                 NB_OP          = 6,
    parameter int                 TIMEOUT_CYCLES = 50000,
    parameter logic [NB_DATA-1:0] ERR_CODE       = NB_DATA'(8'hFF)
) (
    input  logic                 clk,
    input  logic                 i_rst,
    uart_alu_sequencer_if.slave  bus
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_expire;
    logic               w_overrun_evt;
    logic               w_op_bad;
    logic [NB_DATA-1:0] w_tx_byte;

    logic [c_CNT_W-1:0] r_to_cnt;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_tx_start;
    logic               r_timeout;
    logic               r_overrun;

`ifdef UART_ALU_SEQ_OPCHECK_EN
    logic               r_op_err;

    function automatic logic op_is_valid(input logic [NB_OP-1:0] op);
        case (op)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
            NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
            NB_OP'(6'b000011), NB_OP'(6'b000010): op_is_valid = 1'b1;
            default:                              op_is_valid = 1'b0;
        endcase
    endfunction

    assign w_op_bad = !op_is_valid(r_alu_op);
`else
    assign w_op_bad = 1'b0;
`endif

    assign w_tx_byte     = w_op_bad ? ERR_CODE : bus.i_alu_result;
    // A byte arriving while a response is in flight (including the cycle that
    // completes it) is dropped rather than taken as the next operand A.
    assign w_overrun_evt = bus.i_rx_done && (r_state == EXEC || r_state == WAIT_TX);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_rx_done) begin
                    w_accept     = 1'b1;
                    w_next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done) begin
                    w_accept     = 1'b1;
                    w_next_state = WAIT_OP;
                end else if (r_to_cnt == c_CNT_LAST) begin
                    w_expire     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end else if (r_to_cnt == c_CNT_LAST) begin
                    w_expire     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            EXEC: begin
                w_next_state = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.i_tx_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Inter-byte timer only runs while a command is partially received.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (w_accept || w_expire || !(r_state == WAIT_B || r_state == WAIT_OP)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef UART_ALU_SEQ_OPCHECK_EN
            r_op_err   <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_timeout  <= w_expire;
            r_overrun  <= w_overrun_evt;
`ifdef UART_ALU_SEQ_OPCHECK_EN
            r_op_err   <= 1'b0;
`endif
            if (w_accept) begin
                case (r_state)
                    IDLE:    r_alu_a  <= bus.i_rx_data;
                    WAIT_B:  r_alu_b  <= bus.i_rx_data;
                    WAIT_OP: r_alu_op <= bus.i_rx_data[NB_OP-1:0];
                    default: ;
                endcase
            end
            if (r_state == EXEC) begin
                r_tx_data  <= w_tx_byte;
                r_tx_start <= 1'b1;
`ifdef UART_ALU_SEQ_OPCHECK_EN
                r_op_err   <= w_op_bad;
`endif
            end
        end
    end

    assign bus.o_alu_a    = r_alu_a;
    assign bus.o_alu_b    = r_alu_b;
    assign bus.o_alu_op   = r_alu_op;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = r_tx_start;
    assign bus.o_timeout  = r_timeout;
    assign bus.o_overrun  = r_overrun;
    assign bus.o_busy     = (r_state != IDLE);
`ifdef UART_ALU_SEQ_OPCHECK_EN
    assign bus.o_op_err   = r_op_err;
`endif

endmodule

`default_nettype wire

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Command sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in order: operand A, then operand B, then opcode. Drives them to the ALU, captures the combinational ALU result and starts one TX frame with it.
- Adds an inter-byte timeout, overrun flagging while a response is in flight, and a busy indication for the top level.

Parameters:
- NB_DATA, 8, width of UART bytes, ALU operands and result.
- NB_OP, 6, opcode width; the opcode is i_rx_data[NB_OP-1:0].
- TIMEOUT_CYCLES, 50000, idle clock cycles allowed between bytes of one command before it is aborted; must be ≥2. Counter width is $clog2(TIMEOUT_CYCLES+1).
- ERR_CODE, 8'hFF, byte transmitted for a rejected opcode (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe from the UART RX.
- i_alu_result  in  NB_DATA  combinational ALU output for o_alu_a/o_alu_b/o_alu_op.
- i_tx_done  in  1  one-cycle strobe from the UART TX at the end of a frame.
- o_alu_a  out  NB_DATA  registered operand A.
- o_alu_b  out  NB_DATA  registered operand B.
- o_alu_op  out  NB_OP  registered opcode.
- o_tx_data  out  NB_DATA  registered byte to transmit.
- o_tx_start  out  1  one-cycle TX start pulse.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle pulse when a partial command is aborted.
- o_overrun  out  1  one-cycle pulse when a byte arrives in EXEC or WAIT_TX and is dropped.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, timeout counter 0. Reset mid-command discards the partial command and any pending TX wait; the ALU registers are cleared to 0.
- States: IDLE, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
  - IDLE: on i_rx_done, o_alu_a<=i_rx_data, go to WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_b<=i_rx_data, go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_alu_op<=i_rx_data[NB_OP-1:0], go to EXEC.
  - EXEC (exactly one cycle): o_tx_data<=i_alu_result, o_tx_start<=1, go to WAIT_TX.
  - WAIT_TX: o_tx_start<=0 on the next edge. On i_tx_done, go to IDLE.
- Latency: opcode strobe sampled at edge N; o_tx_start is high for the cycle following edge N+1; o_tx_data is stable from edge N+1 until the next EXEC.
- Operand and opcode registers hold their values until overwritten. The ALU inputs remain valid after the response.
- Timeout:
  - The counter clears on every accepted byte and on entry to WAIT_B.
  - It increments each cycle in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done in that cycle: o_timeout pulses, the state goes to IDLE, the counter clears, and o_alu_* are unchanged.
  - If i_rx_done coincides with the expiry cycle, the byte wins and no timeout occurs.
  - There is no timeout in IDLE, EXEC or WAIT_TX.
- Overrun: i_rx_done in EXEC or WAIT_TX drops the byte and pulses o_overrun in the next cycle. The state is unaffected.
- i_tx_done outside WAIT_TX is ignored.
- i_tx_done in the same cycle as o_tx_start is high counts as completion: go to IDLE.
- i_rx_done in the cycle the FSM returns to IDLE from WAIT_TX is an overrun; the byte is not taken as A.
- o_busy is a function of the registered state only.

Optional Feature:
- Macro: UART_ALU_SEQ_OPCHECK_EN.
- Defined:
  - In EXEC, the opcode is checked against the valid set: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.
  - Invalid opcode: o_tx_data<=ERR_CODE instead of i_alu_result, and an extra port o_op_err (out, 1) pulses together with o_tx_start. Sequencing and timing are otherwise identical.
- Undefined: no o_op_err port; every opcode is forwarded and the ALU result is always transmitted.

Test Plan:
- Reset, then bytes 8'h05, 8'h03, 8'h20 (ADD) with the ALU model returning 8'h08 -> o_alu_a=05, o_alu_b=03, o_alu_op=6'h20; o_tx_data=8'h08; o_tx_start a single pulse 2 edges after the opcode strobe; o_busy high until i_tx_done.
- Send 8'h05 only, idle TIMEOUT_CYCLES cycles (bench with TIMEOUT_CYCLES=16) -> o_timeout pulses once, state IDLE; the next three bytes form a fresh command.
- Byte strobe in exactly the expiry cycle in WAIT_OP -> no o_timeout; the command completes.
- Strobe i_rx_done twice during WAIT_TX -> two o_overrun pulses, o_alu_a unchanged; after i_tx_done, a new command is accepted normally.
- Assert i_rst in WAIT_OP and in WAIT_TX -> all outputs 0 asynchronously, o_busy=0, no o_tx_start afterwards.
- With UART_ALU_SEQ_OPCHECK_EN: opcode 6'h3F -> o_tx_data=8'hFF and o_op_err pulse; opcode 6'h22 -> ALU result sent, no o_op_err.
